// File: rtl/thor_pkg.sv
// Shared constants and types for the dual-issue instruction queue.
package thor_pkg;

    localparam int unsigned IWORD_W = 30;

    // NOP (32'h00000013) with the two always-zero low bits stripped
    localparam logic [IWORD_W-1:0] NOP_WORD_DEF = 30'h0000004;

    // Two-bit slot count carried by push_cnt and pop_cnt (0, 1 or 2 legal)
    typedef logic [1:0] slot_cnt_t;

    // Illegal count 3 behaves as 0
    function automatic slot_cnt_t legal_cnt(input slot_cnt_t c);
        return (c == 2'd3) ? 2'd0 : c;
    endfunction

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping and push acceptance for the queue.
module iq_ptr_ctrl
    import thor_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  slot_cnt_t     push_cnt,
    input  slot_cnt_t     pop_cnt,
    output logic [PW-1:0] head,
    output logic [PW-1:0] tail,
    output logic [CW-1:0] count,
    output logic          push_ack,
    output logic          wr_one,
    output logic          wr_two,
    output logic          err
);

    slot_cnt_t     push_ok;
    slot_cnt_t     pop_ok;
    logic [CW-1:0] free;
    logic [CW-1:0] push_acc;
    logic [CW-1:0] pop_req;
    logic [CW-1:0] pop_eff;

    // Acceptance uses registered occupancy only; a same-cycle pop frees nothing
    always_comb begin
        push_ok  = legal_cnt(push_cnt);
        pop_ok   = legal_cnt(pop_cnt);
        free     = CW'(DEPTH) - count;
        push_ack = (push_ok != 2'd0) && (CW'(push_ok) <= free);
        push_acc = push_ack ? CW'(push_ok) : '0;
        pop_req  = CW'(pop_ok);
        pop_eff  = (pop_req < count) ? pop_req : count;
        wr_one   = push_ack && !flush && !reset;
        wr_two   = wr_one && (push_ok == 2'd2);
    end

    // Pointer/count update; reset beats flush, flush beats push/pop, err is sticky
    always_ff @(posedge clock) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            err <= err | (push_cnt == 2'd3) | (pop_cnt == 2'd3);
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PW'(pop_eff);
                tail  <= tail + PW'(push_acc);
                count <= count + push_acc - pop_eff;
            end
        end
    end

endmodule

// File: rtl/instr_queue_dual.sv
// Two-in/two-out instruction queue: storage and output muxing around iq_ptr_ctrl.
module instr_queue_dual
    import thor_pkg::*;
#(
    parameter int unsigned        WIDTH     = 30,
    parameter int unsigned        DEPTH     = 8,
    parameter logic [WIDTH-1:0]   NOP_WORD  = WIDTH'(NOP_WORD_DEF),
    parameter int unsigned        AFULL_LVL = DEPTH - 2,
    localparam int unsigned       PW        = $clog2(DEPTH),
    localparam int unsigned       CW        = PW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  slot_cnt_t        push_cnt,
    input  logic [WIDTH-1:0] push_data0,
    input  logic [WIDTH-1:0] push_data1,
    input  slot_cnt_t        pop_cnt,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [1:0]       out_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             push_ack,
    output logic             err
);

    // Pointer arithmetic relies on natural wrap, so DEPTH must be 2^n >= 4
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("instr_queue_dual: DEPTH must be a power of two and at least 4");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic             wr_one;
    logic             wr_two;

    iq_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
        .clock    (clock),
        .reset    (reset),
        .flush    (flush),
        .push_cnt (push_cnt),
        .pop_cnt  (pop_cnt),
        .head     (head),
        .tail     (tail),
        .count    (count),
        .push_ack (push_ack),
        .wr_one   (wr_one),
        .wr_two   (wr_two),
        .err      (err)
    );

    // Storage writes; contents survive flush and reset, only pointers clear
    always_ff @(posedge clock) begin
        if (wr_one) mem[tail] <= push_data0;
        if (wr_two) mem[tail + PW'(1)] <= push_data1;
    end

    // Outputs come from registered head/count/storage only (no write bypass)
    always_comb begin
        out_a       = (count >= CW'(1)) ? mem[head] : NOP_WORD;
        out_b       = (count >= CW'(2)) ? mem[head + PW'(1)] : NOP_WORD;
        out_valid   = {count >= CW'(2), count >= CW'(1)};
        empty       = (count == '0);
        full        = (count == CW'(DEPTH));
        almost_full = (32'(count) >= AFULL_LVL);
    end

endmodule

// File: tb/tb_instr_queue_dual.sv
// Self-checking bench: directed vector table, wrap sequence, randomized run vs queue model.
module tb_instr_queue_dual;
    import thor_pkg::*;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned W     = 30;
    localparam int unsigned CW    = 4;
    localparam int unsigned AF    = DEPTH - 2;
    localparam logic [W-1:0] NOP  = 30'h0000004;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic [1:0]    push_cnt = 2'd0;
    logic [1:0]    pop_cnt = 2'd0;
    logic [W-1:0]  push_data0 = '0;
    logic [W-1:0]  push_data1 = '0;
    logic [W-1:0]  out_a, out_b;
    logic [1:0]    out_valid;
    logic [CW-1:0] count;
    logic          empty, full, almost_full, push_ack, err;

    instr_queue_dual #(.WIDTH(W), .DEPTH(DEPTH), .NOP_WORD(NOP), .AFULL_LVL(AF)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .push_cnt(push_cnt), .push_data0(push_data0), .push_data1(push_data1),
        .pop_cnt(pop_cnt), .out_a(out_a), .out_b(out_b), .out_valid(out_valid),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full),
        .push_ack(push_ack), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Directed vector: inputs for one cycle and the state expected after the edge
    typedef struct {
        logic       rst, fl;
        logic [1:0] pu;
        logic [W-1:0] d0, d1;
        logic [1:0] po;
        logic       chk_ack, ack;
        int         cnt;
        logic [W-1:0] a, b;
        logic [1:0] v;
        logic       e, f, af, er;
    } vec_t;

    function automatic vec_t mk(input logic rst, fl, input logic [1:0] pu, input int d0, d1,
                                input logic [1:0] po, input logic chk_ack, ack, input int cnt,
                                input int a, b, input logic [1:0] v, input logic e, f, af, er);
        vec_t r;
        r.rst = rst; r.fl = fl; r.pu = pu; r.d0 = W'(d0); r.d1 = W'(d1); r.po = po;
        r.chk_ack = chk_ack; r.ack = ack; r.cnt = cnt; r.a = W'(a); r.b = W'(b); r.v = v;
        r.e = e; r.f = f; r.af = af; r.er = er;
        return r;
    endfunction

    task automatic apply_vec(input int i, input vec_t t);
        reset = t.rst; flush = t.fl; push_cnt = t.pu; pop_cnt = t.po;
        push_data0 = t.d0; push_data1 = t.d1;
        #1;
        if (t.chk_ack) chk($sformatf("v%0d_push_ack", i), 32'(push_ack), 32'(t.ack));
        @(posedge clock);
        #1;
        chk($sformatf("v%0d_count", i), 32'(count), 32'(t.cnt));
        chk($sformatf("v%0d_out_a", i), 32'(out_a), 32'(t.a));
        chk($sformatf("v%0d_out_b", i), 32'(out_b), 32'(t.b));
        chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(t.v));
        chk($sformatf("v%0d_flags", i), {28'd0, empty, full, almost_full, err},
            {28'd0, t.e, t.f, t.af, t.er});
    endtask

    // Reference model: a plain FIFO of words plus a sticky error bit
    logic [W-1:0] mq[$];
    logic         m_err = 1'b0;

    task automatic step(input logic rst, fl, input logic [1:0] pu, input logic [W-1:0] d0, d1,
                        input logic [1:0] po, output logic acc);
        int pc, oc, pe;
        logic ack;
        reset = rst; flush = fl; push_cnt = pu; pop_cnt = po;
        push_data0 = d0; push_data1 = d1;
        pc  = (pu == 2'd3) ? 0 : int'(pu);
        oc  = (po == 2'd3) ? 0 : int'(po);
        ack = (pc != 0) && (pc <= int'(DEPTH) - mq.size());
        #1;
        if (!rst && !fl) chk("rand_push_ack", 32'(push_ack), 32'(ack));
        @(posedge clock);
        acc = 1'b0;
        if (rst) begin
            mq.delete();
            m_err = 1'b0;
        end else begin
            if (pu == 2'd3 || po == 2'd3) m_err = 1'b1;
            if (fl) begin
                mq.delete();
            end else begin
                pe = (oc < mq.size()) ? oc : mq.size();
                for (int k = 0; k < pe; k++) void'(mq.pop_front());
                if (ack) begin
                    acc = 1'b1;
                    mq.push_back(d0);
                    if (pc == 2) mq.push_back(d1);
                end
            end
        end
        #1;
        chk("m_count", 32'(count), 32'(mq.size()));
        chk("m_out_a", 32'(out_a), 32'((mq.size() >= 1) ? mq[0] : NOP));
        chk("m_out_b", 32'(out_b), 32'((mq.size() >= 2) ? mq[1] : NOP));
        chk("m_out_valid", 32'(out_valid), {30'd0, mq.size() >= 2, mq.size() >= 1});
        chk("m_flags", {28'd0, empty, full, almost_full, err},
            {28'd0, mq.size() == 0, mq.size() == int'(DEPTH), mq.size() >= int'(AF), m_err});
    endtask

    initial begin
        vec_t tbl[$];
        logic [W-1:0] got[$];
        logic acc;
        int nxt;

        // rst fl pu d0 d1 po | chk ack | cnt a b v | e f af er
        tbl.push_back(mk(1,0,0,   0,   0,0, 1,0, 0,   4,   4,0, 1,0,0,0));
        tbl.push_back(mk(0,0,2,   1,   2,0, 1,1, 2,   1,   2,3, 0,0,0,0));
        tbl.push_back(mk(0,0,2,   3,   4,0, 1,1, 4,   1,   2,3, 0,0,0,0));
        tbl.push_back(mk(0,0,2,   5,   6,0, 1,1, 6,   1,   2,3, 0,0,1,0));
        tbl.push_back(mk(0,0,1,   7,   0,0, 1,1, 7,   1,   2,3, 0,0,1,0));
        tbl.push_back(mk(0,0,2,   8,   9,0, 1,0, 7,   1,   2,3, 0,0,1,0));
        tbl.push_back(mk(0,0,1,   8,   0,0, 1,1, 8,   1,   2,3, 0,1,1,0));
        tbl.push_back(mk(0,0,0,   0,   0,2, 1,0, 6,   3,   4,3, 0,0,1,0));
        tbl.push_back(mk(0,0,0,   0,   0,2, 1,0, 4,   5,   6,3, 0,0,0,0));
        tbl.push_back(mk(0,0,0,   0,   0,2, 1,0, 2,   7,   8,3, 0,0,0,0));
        tbl.push_back(mk(0,0,0,   0,   0,1, 1,0, 1,   8,   4,1, 0,0,0,0));
        tbl.push_back(mk(0,0,2,   9,'hA,2, 1,1, 2,   9,'hA,3, 0,0,0,0));
        tbl.push_back(mk(0,0,2,'hB,'hC,0, 1,1, 4,   9,'hA,3, 0,0,0,0));
        tbl.push_back(mk(0,0,1,'hD,   0,0, 1,1, 5,   9,'hA,3, 0,0,0,0));
        tbl.push_back(mk(0,1,2,'hE,'hF,0, 0,0, 0,   4,   4,0, 1,0,0,0));
        tbl.push_back(mk(0,0,0,   0,   0,3, 1,0, 0,   4,   4,0, 1,0,0,1));
        tbl.push_back(mk(0,0,2,'h10,'h11,0,1,1, 2,'h10,'h11,3,0,0,0,1));
        tbl.push_back(mk(0,0,0,   0,   0,0, 1,0, 2,'h10,'h11,3,0,0,0,1));
        tbl.push_back(mk(1,0,2,'h20,'h21,1,0,0, 0,   4,   4,0, 1,0,0,0));
        tbl.push_back(mk(0,0,3,'h30,'h31,0,1,0, 0,   4,   4,0, 1,0,0,1));
        tbl.push_back(mk(1,0,0,   0,   0,0, 1,0, 0,   4,   4,0, 1,0,0,0));

        foreach (tbl[i]) apply_vec(i, tbl[i]);

        // Wrap sequence: 20 words through 8 entries, alternating push-2 and pop-1/2
        step(1, 0, 0, '0, '0, 0, acc);
        nxt = 0;
        for (int c = 0; c < 200 && (nxt < 20 || mq.size() > 0); c++) begin
            if (c % 2 == 0 && nxt < 20) begin
                step(0, 0, 2, W'(nxt), W'(nxt + 1), 0, acc);
                if (acc) nxt += 2;
            end else begin
                logic [1:0] po;
                po = (c % 4 == 1) ? 2'd1 : 2'd2;
                if (po >= 2'd1 && out_valid[0]) got.push_back(out_a);
                if (po == 2'd2 && out_valid[1]) got.push_back(out_b);
                step(0, 0, 0, '0, '0, po, acc);
            end
        end
        chk("wrap_len", 32'(got.size()), 32'd20);
        for (int i = 0; i < got.size() && i < 20; i++)
            chk($sformatf("wrap_word%0d", i), 32'(got[i]), 32'(i));

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            logic rs, fl;
            logic [1:0] pu, po;
            rs = ($urandom_range(0, 63) == 0);
            fl = ($urandom_range(0, 15) == 0);
            pu = ($urandom_range(0, 31) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            po = ($urandom_range(0, 31) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            step(rs, fl, pu, W'($urandom), W'($urandom), po, acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
